// File: rtl/operand_byte_loader_pkg.sv
// Shared definitions for the byte-serial operand loader: state encoding,
// frame length and the default inter-byte timeout.
package operand_loader_pkg;

    typedef enum logic [2:0] {
        A_HI = 3'd0,
        A_LO = 3'd1,
        B_HI = 3'd2,
        B_LO = 3'd3,
        HOLD = 3'd4
    } state_e;

    localparam int BYTES_PER_FRAME        = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/operand_byte_loader_if.sv
// Byte input and operand-pair output bundle between the byte source,
// the loader and the downstream multiplier.
interface operand_byte_loader_if;

    logic [7:0]  byte_in;
    logic        byte_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        op_valid;
    logic        op_ready;

    modport master (
        output byte_in,
        output byte_valid,
        input  a,
        input  b,
        input  op_valid,
        output op_ready
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output a,
        output b,
        input  op_ready,
        output op_valid
    );

endinterface

// File: rtl/operand_byte_loader_idle_timer.sv
// Idle-cycle counter for a partially loaded frame; expired fires on the
// cycle whose count would reach TIMEOUT_CYCLES.
module idle_timer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic run,
    input  logic reload,
    output logic expired
);

    logic [TIMEOUT_W-1:0] count;

    // Reload takes priority so that an expiry restarts the count at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (reload) begin
            count <= '0;
        end else if (ena && run) begin
            count <= count + TIMEOUT_W'(1);
        end
    end

    assign expired = ena && run && (count == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/operand_byte_loader.sv
// Assembles four big-endian bytes into 16-bit operands a and b and hands
// the pair to the multiplier over a valid/ready handshake.
module operand_byte_loader
    import operand_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int TIMEOUT_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   clear,
    operand_byte_loader_if.slave   bus,
    output logic                   busy,
    output logic                   timeout_err,
    output logic                   overrun_err,
    output logic [2:0]             state_dbg
);

    localparam logic [2:0] S_A_HI = A_HI;
    localparam logic [2:0] S_A_LO = A_LO;
    localparam logic [2:0] S_B_HI = B_HI;
    localparam logic [2:0] S_B_LO = B_LO;
    localparam logic [2:0] S_HOLD = HOLD;

    logic [2:0]  state;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic        op_valid_q;
    logic        is_load;
    logic        accept_load;
    logic        timer_run;
    logic        timer_reload;
    logic        expired;

    assign is_load      = state < 3'(BYTES_PER_FRAME);
    assign accept_load  = ena && !clear && bus.byte_valid && is_load;
    // Only the partially loaded states age; A_HI and HOLD wait forever.
    assign timer_run    = is_load && (state != S_A_HI) && !accept_load;
    assign timer_reload = clear || (ena && (!timer_run || expired));

    idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_W      (TIMEOUT_W)
    ) u_idle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .run     (timer_run),
        .reload  (timer_reload),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_A_HI;
            a_q         <= '0;
            b_q         <= '0;
            op_valid_q  <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else if (clear) begin
            state       <= S_A_HI;
            op_valid_q  <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else if (ena) begin
            case (state)
                S_A_HI: begin
                    if (bus.byte_valid) begin
                        a_q[15:8] <= bus.byte_in;
                        state     <= S_A_LO;
                    end
                end
                S_A_LO: begin
                    if (bus.byte_valid) begin
                        a_q[7:0] <= bus.byte_in;
                        state    <= S_B_HI;
                    end else if (expired) begin
                        state       <= S_A_HI;
                        timeout_err <= 1'b1;
                    end
                end
                S_B_HI: begin
                    if (bus.byte_valid) begin
                        b_q[15:8] <= bus.byte_in;
                        state     <= S_B_LO;
                    end else if (expired) begin
                        state       <= S_A_HI;
                        timeout_err <= 1'b1;
                    end
                end
                S_B_LO: begin
                    if (bus.byte_valid) begin
                        b_q[7:0]   <= bus.byte_in;
                        state      <= S_HOLD;
                        op_valid_q <= 1'b1;
                    end else if (expired) begin
                        state       <= S_A_HI;
                        timeout_err <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (bus.op_ready) begin
                        op_valid_q <= 1'b0;
                        // A byte in the transfer cycle starts the next frame
                        // immediately, giving four cycles per pair.
                        if (bus.byte_valid) begin
                            a_q[15:8] <= bus.byte_in;
                            state     <= S_A_LO;
                        end else begin
                            state <= S_A_HI;
                        end
                    end else if (bus.byte_valid) begin
                        overrun_err <= 1'b1;
                    end
                end
                default: begin
                    state      <= S_A_HI;
                    op_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a        = a_q;
    assign bus.b        = b_q;
    assign bus.op_valid = op_valid_q;
    assign busy         = (state == S_A_LO) || (state == S_B_HI) || (state == S_B_LO);
    assign state_dbg    = state;

endmodule

// File: tb/tb_operand_byte_loader.sv
// Self-checking bench for operand_byte_loader: vector table, directed
// corner sequences and random traffic against a frame-level model.
module tb_operand_byte_loader;

    localparam int TO = 4;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       clear;
    logic       busy;
    logic       timeout_err;
    logic       overrun_err;
    logic [2:0] state_dbg;

    operand_byte_loader_if bus ();

    operand_byte_loader #(
        .TIMEOUT_CYCLES (TO),
        .TIMEOUT_W      (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .clear       (clear),
        .bus         (bus.slave),
        .busy        (busy),
        .timeout_err (timeout_err),
        .overrun_err (overrun_err),
        .state_dbg   (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a list of bytes collected so far, the held pair and
    // an idle-cycle count; no notion of the RTL state machine.
    logic [7:0]  m_bytes[$];
    bit          m_held;
    logic [15:0] m_a, m_b;
    int          m_idle;
    bit          m_to, m_ov;

    task automatic model_step(input logic r, input logic e, input logic c,
                              input logic v, input logic [7:0] d, input logic rdy);
        if (!r) begin
            m_bytes.delete(); m_held = 0; m_a = 0; m_b = 0;
            m_idle = 0; m_to = 0; m_ov = 0;
        end else if (c) begin
            m_bytes.delete(); m_held = 0; m_idle = 0; m_to = 0; m_ov = 0;
        end else if (e) begin
            if (m_held) begin
                if (rdy) begin
                    m_held = 0;
                    if (v) begin
                        m_bytes.push_back(d);
                        m_a = {d, m_a[7:0]};
                    end
                end else if (v) begin
                    m_ov = 1;
                end
                m_idle = 0;
            end else if (v) begin
                case (m_bytes.size())
                    0: m_a = {d, m_a[7:0]};
                    1: m_a = {m_a[15:8], d};
                    2: m_b = {d, m_b[7:0]};
                    default: m_b = {m_b[15:8], d};
                endcase
                m_bytes.push_back(d);
                m_idle = 0;
                if (m_bytes.size() == 4) begin
                    m_held = 1;
                    m_bytes.delete();
                end
            end else if (m_bytes.size() > 0) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_bytes.delete();
                    m_to = 1;
                    m_idle = 0;
                end
            end
        end
    endtask

    task automatic check_model();
        chk("model_op_valid", 32'(bus.op_valid), 32'(m_held));
        chk("model_busy", 32'(busy), 32'(!m_held && m_bytes.size() > 0));
        chk("model_state", 32'(state_dbg), m_held ? 32'd4 : 32'(m_bytes.size()));
        chk("model_a", 32'(bus.a), 32'(m_a));
        chk("model_b", 32'(bus.b), 32'(m_b));
        chk("model_timeout_err", 32'(timeout_err), 32'(m_to));
        chk("model_overrun_err", 32'(overrun_err), 32'(m_ov));
    endtask

    task automatic cyc(input logic e, input logic c, input logic v,
                       input logic [7:0] d, input logic rdy);
        logic r;
        ena = e; clear = c; bus.byte_valid = v; bus.byte_in = d; bus.op_ready = rdy;
        r = rst_n;
        @(posedge clk);
        model_step(r, e, c, v, d, rdy);
        #1;
        check_model();
    endtask

    typedef struct {
        logic        e, c, v;
        logic [7:0]  d;
        logic        rdy;
        logic        x_valid;
        logic [2:0]  x_state;
        logic [15:0] x_a, x_b;
        logic        x_to, x_ov;
    } vec_t;

    vec_t tbl[16];
    int   pulse_at[$];

    initial begin
        // frame 00 12 00 0F, then timeout after AB CD, then frame 00 03 00 05
        tbl[0]  = '{1,0,1,8'h00,1, 0,3'd1,16'h0000,16'h0000, 0,0};
        tbl[1]  = '{1,0,1,8'h12,1, 0,3'd2,16'h0012,16'h0000, 0,0};
        tbl[2]  = '{1,0,1,8'h00,1, 0,3'd3,16'h0012,16'h0000, 0,0};
        tbl[3]  = '{1,0,1,8'h0F,1, 1,3'd4,16'h0012,16'h000F, 0,0};
        tbl[4]  = '{1,0,0,8'h00,1, 0,3'd0,16'h0012,16'h000F, 0,0};
        tbl[5]  = '{1,0,1,8'hAB,1, 0,3'd1,16'hAB12,16'h000F, 0,0};
        tbl[6]  = '{1,0,1,8'hCD,1, 0,3'd2,16'hABCD,16'h000F, 0,0};
        tbl[7]  = '{1,0,0,8'h00,1, 0,3'd2,16'hABCD,16'h000F, 0,0};
        tbl[8]  = '{1,0,0,8'h00,1, 0,3'd2,16'hABCD,16'h000F, 0,0};
        tbl[9]  = '{1,0,0,8'h00,1, 0,3'd2,16'hABCD,16'h000F, 0,0};
        tbl[10] = '{1,0,0,8'h00,1, 0,3'd0,16'hABCD,16'h000F, 1,0};
        tbl[11] = '{1,0,1,8'h00,1, 0,3'd1,16'h00CD,16'h000F, 1,0};
        tbl[12] = '{1,0,1,8'h03,1, 0,3'd2,16'h0003,16'h000F, 1,0};
        tbl[13] = '{1,0,1,8'h00,1, 0,3'd3,16'h0003,16'h000F, 1,0};
        tbl[14] = '{1,0,1,8'h05,1, 1,3'd4,16'h0003,16'h0005, 1,0};
        tbl[15] = '{1,0,0,8'h00,1, 0,3'd0,16'h0003,16'h0005, 1,0};

        rst_n = 1'b0;
        cyc(0, 0, 0, 8'h00, 0);
        chk("reset_state", 32'(state_dbg), 32'd0);
        chk("reset_a", 32'(bus.a), 32'd0);
        chk("reset_flags", 32'({bus.op_valid, busy, timeout_err, overrun_err}), 32'd0);
        cyc(0, 0, 0, 8'h00, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].e, tbl[i].c, tbl[i].v, tbl[i].d, tbl[i].rdy);
            chk($sformatf("tbl%0d_op_valid", i), 32'(bus.op_valid), 32'(tbl[i].x_valid));
            chk($sformatf("tbl%0d_state", i), 32'(state_dbg), 32'(tbl[i].x_state));
            chk($sformatf("tbl%0d_a", i), 32'(bus.a), 32'(tbl[i].x_a));
            chk($sformatf("tbl%0d_b", i), 32'(bus.b), 32'(tbl[i].x_b));
            chk($sformatf("tbl%0d_timeout_err", i), 32'(timeout_err), 32'(tbl[i].x_to));
            chk($sformatf("tbl%0d_overrun_err", i), 32'(overrun_err), 32'(tbl[i].x_ov));
            if (i == 3) chk("product", 32'(bus.a) * 32'(bus.b), 32'h010E);
        end

        // back-to-back frames, second A_HI in the transfer cycle
        cyc(1, 1, 0, 8'h00, 0);
        begin
            logic [7:0] seq[8];
            seq = '{8'h01, 8'h00, 8'h00, 8'h02, 8'hFF, 8'hFF, 8'h00, 8'h01};
            for (int i = 0; i < 9; i++) begin
                if (i < 8) cyc(1, 0, 1, seq[i], 1);
                else       cyc(1, 0, 0, 8'h00, 1);
                if (bus.op_valid) begin
                    pulse_at.push_back(i);
                    if (pulse_at.size() == 1)
                        chk("b2b_pair1", {bus.a, bus.b}, 32'h0100_0002);
                    else
                        chk("b2b_pair2", {bus.a, bus.b}, 32'hFFFF_0001);
                end
            end
            chk("b2b_pulses", 32'(pulse_at.size()), 32'd2);
            if (pulse_at.size() == 2) chk("b2b_gap", 32'(pulse_at[1] - pulse_at[0]), 32'd4);
        end

        // overrun while held, then transfer, then clear
        cyc(1, 0, 1, 8'hDE, 0);
        cyc(1, 0, 1, 8'hAD, 0);
        cyc(1, 0, 1, 8'hBE, 0);
        cyc(1, 0, 1, 8'hEF, 0);
        cyc(1, 0, 1, 8'h77, 0);
        chk("ovr_flag", 32'(overrun_err), 32'd1);
        chk("ovr_hold", {bus.a, bus.b}, 32'hDEAD_BEEF);
        chk("ovr_valid", 32'(bus.op_valid), 32'd1);
        cyc(1, 0, 0, 8'h00, 1);
        chk("ovr_xfer", 32'(bus.op_valid), 32'd0);
        cyc(1, 0, 0, 8'h00, 1);
        chk("ovr_single", 32'(bus.op_valid), 32'd0);
        cyc(0, 1, 1, 8'h55, 0);
        chk("clear_flags", 32'({timeout_err, overrun_err}), 32'd0);

        // ena low mid-frame
        cyc(1, 0, 1, 8'h12, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 1'(i % 2), 8'(8'hA0 + i), 1);
            chk("freeze_state", 32'(state_dbg), 32'd1);
        end
        chk("freeze_no_to", 32'(timeout_err), 32'd0);
        cyc(1, 0, 1, 8'h34, 0);
        cyc(1, 0, 1, 8'h56, 0);
        cyc(1, 0, 1, 8'h78, 0);
        chk("freeze_pair", {bus.a, bus.b}, 32'h1234_5678);
        chk("freeze_valid", 32'(bus.op_valid), 32'd1);
        cyc(1, 0, 0, 8'h00, 1);

        // reset in B_LO
        cyc(1, 0, 1, 8'h11, 0);
        cyc(1, 0, 1, 8'h22, 0);
        cyc(1, 0, 1, 8'h33, 0);
        chk("pre_rst_state", 32'(state_dbg), 32'd3);
        rst_n = 1'b0;
        cyc(1, 0, 1, 8'h44, 0);
        rst_n = 1'b1;
        chk("rst_state", 32'(state_dbg), 32'd0);
        chk("rst_outputs", {bus.a, bus.b}, 32'd0);
        cyc(1, 0, 1, 8'h9A, 0);
        cyc(1, 0, 1, 8'hBC, 0);
        cyc(1, 0, 1, 8'hDE, 0);
        cyc(1, 0, 1, 8'hF0, 0);
        chk("rst_fresh", {bus.a, bus.b}, 32'h9ABC_DEF0);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 9) < 6, 8'($urandom), 1'($urandom_range(0, 1)));
            rst_n = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
